// File: rtl/iobus_uart_pkg.sv
// Shared constants, FSM state type and parity helper for the IO-bus UART transmitter.
package iobus_uart_pkg;

  localparam logic [3:0] TXDATA_OFS = 4'h0;
  localparam logic [3:0] STATUS_OFS = 4'h4;
  localparam logic [3:0] BAUD_OFS   = 4'h8;

  localparam int STAT_BUSY    = 0;
  localparam int STAT_FULL    = 1;
  localparam int STAT_EMPTY   = 2;
  localparam int STAT_OVR     = 3;
  localparam int STAT_PAR     = 4;
  localparam int STAT_CNT_LSB = 8;

  localparam logic [15:0] MIN_DIV = 16'd16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  function automatic logic evenParity(input logic [7:0] d);
    return ^d;
  endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous FIFO with combinational read port; DEPTH must be a power of 2, count spans 0..DEPTH.
module uart_tx_fifo #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 8
) (
  input  logic                   CPU_CLK,
  input  logic                   CPU_RST_N,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wrPtr_r;
  logic [PTR_W-1:0] rdPtr_r;
  logic [PTR_W:0]   count_r;
  logic             doPush_s;
  logic             doPop_s;

  // A push into a full FIFO is only accepted when a pop frees a slot in the same cycle.
  always_comb begin
    doPop_s  = pop && (count_r != '0);
    doPush_s = push && ((count_r != (PTR_W+1)'(DEPTH)) || doPop_s);
  end

  // Pointer and occupancy registers.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      wrPtr_r <= '0;
      rdPtr_r <= '0;
      count_r <= '0;
    end else begin
      if (doPush_s) wrPtr_r <= wrPtr_r + PTR_W'(1'b1);
      if (doPop_s)  rdPtr_r <= rdPtr_r + PTR_W'(1'b1);
      case ({doPush_s, doPop_s})
        2'b10:   count_r <= count_r + (PTR_W+1)'(1'b1);
        2'b01:   count_r <= count_r - (PTR_W+1)'(1'b1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Storage array.
  always_ff @(posedge CPU_CLK) begin
    if (doPush_s) mem_r[wrPtr_r] <= din;
  end

  assign dout  = mem_r[rdPtr_r];
  assign full  = (count_r == (PTR_W+1)'(DEPTH));
  assign empty = (count_r == '0);
  assign count = count_r;

endmodule

// File: rtl/iobus_uart_tx.sv
// IO-bus UART transmitter: TXDATA/STATUS/BAUD_DIV registers, TX FIFO and 8N1 serialiser.
// Define IOBUS_UART_PARITY_EN to add an even parity bit (8E1 frame).
module iobus_uart_tx
  import iobus_uart_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR  = 32'h1100_0100,
  parameter int          FIFO_DEPTH = 16,
  parameter logic [15:0] DIV_RESET  = 16'd868
) (
  input  logic        CPU_CLK,
  input  logic        CPU_RST_N,
  input  logic [31:0] IOBUS_ADDR,
  input  logic [31:0] IOBUS_OUT,
  input  logic        IOBUS_WR,
  output logic [31:0] RD_DATA,
  output logic        RD_HIT,
  output logic        UART_TXD
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
`ifdef IOBUS_UART_PARITY_EN
  localparam logic      PARITY_ON  = 1'b1;
  localparam tx_state_t AFTER_DATA = PARITY;
`else
  localparam logic      PARITY_ON  = 1'b0;
  localparam tx_state_t AFTER_DATA = STOP;
`endif

  logic [31:0]      offset_s;
  logic [3:0]       regOfs_s;
  logic             hit_s;
  logic             wrTx_s;
  logic             wrStatus_s;
  logic             wrBaud_s;
  logic [31:0]      statusWord_s;
  logic [31:0]      rdData_s;
  logic             unusedBits_s;

  logic [15:0]      baudDiv_r;
  logic             overrun_r;

  logic [7:0]       fifoDout_s;
  logic             fifoFull_s;
  logic             fifoEmpty_s;
  logic [CNT_W-1:0] fifoCount_s;
  logic             popReq_s;

  tx_state_t        state_r;
  tx_state_t        nextState_s;
  logic [15:0]      baudCnt_r;
  logic [15:0]      nextBaud_s;
  logic [15:0]      bitPeriod_r;
  logic [15:0]      nextPeriod_s;
  logic [2:0]       bitIdx_r;
  logic [2:0]       nextBitIdx_s;
  logic [7:0]       shift_r;
  logic [7:0]       nextShift_s;
  logic             bitEnd_s;
  logic             loadFrame_s;
  logic             txd_r;
  logic             nextTxd_s;
`ifdef IOBUS_UART_PARITY_EN
  logic             parity_r;
  logic             nextParity_s;
`endif

  // Address decode: offset 0xC and anything outside the 16-byte block miss.
  always_comb begin
    offset_s   = IOBUS_ADDR - BASE_ADDR;
    regOfs_s   = {offset_s[3:2], 2'b00};
    hit_s      = (offset_s[31:4] == 28'd0) && (regOfs_s != 4'hC);
    wrTx_s     = IOBUS_WR && hit_s && (regOfs_s == TXDATA_OFS);
    wrStatus_s = IOBUS_WR && hit_s && (regOfs_s == STATUS_OFS);
    wrBaud_s   = IOBUS_WR && hit_s && (regOfs_s == BAUD_OFS);
  end

  assign unusedBits_s = ^{IOBUS_OUT[31:16], offset_s[1:0]};

  // Combinational read mux.
  always_comb begin
    statusWord_s             = 32'd0;
    statusWord_s[STAT_BUSY]  = (state_r != IDLE);
    statusWord_s[STAT_FULL]  = fifoFull_s;
    statusWord_s[STAT_EMPTY] = fifoEmpty_s;
    statusWord_s[STAT_OVR]   = overrun_r;
    statusWord_s[STAT_PAR]   = PARITY_ON;
    statusWord_s[STAT_CNT_LSB +: CNT_W] = fifoCount_s;
    if (hit_s) begin
      case (regOfs_s)
        STATUS_OFS: rdData_s = statusWord_s;
        BAUD_OFS:   rdData_s = {16'd0, baudDiv_r};
        default:    rdData_s = 32'd0;
      endcase
    end else begin
      rdData_s = 32'd0;
    end
  end

  assign RD_DATA = rdData_s;
  assign RD_HIT  = hit_s;

  uart_tx_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .CPU_CLK   (CPU_CLK),
    .CPU_RST_N (CPU_RST_N),
    .push      (wrTx_s),
    .pop       (popReq_s),
    .din       (IOBUS_OUT[7:0]),
    .dout      (fifoDout_s),
    .full      (fifoFull_s),
    .empty     (fifoEmpty_s),
    .count     (fifoCount_s)
  );

  // BAUD_DIV and sticky overrun flag.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      baudDiv_r <= DIV_RESET;
      overrun_r <= 1'b0;
    end else begin
      if (wrBaud_s) baudDiv_r <= (IOBUS_OUT[15:0] < MIN_DIV) ? MIN_DIV : IOBUS_OUT[15:0];
      if (wrTx_s && fifoFull_s && !popReq_s) overrun_r <= 1'b1;
      else if (wrStatus_s && IOBUS_OUT[STAT_OVR]) overrun_r <= 1'b0;
    end
  end

  // Serialiser next-state logic; the line level is computed from the next state so TXD is a flop.
  always_comb begin
    nextState_s  = state_r;
    nextBaud_s   = 16'd0;
    nextBitIdx_s = bitIdx_r;
    nextShift_s  = shift_r;
    nextPeriod_s = bitPeriod_r;
    loadFrame_s  = 1'b0;
    nextTxd_s    = 1'b1;
    bitEnd_s     = (baudCnt_r == (bitPeriod_r - 16'd1));
    if ((state_r == IDLE) || bitEnd_s) nextBaud_s = 16'd0;
    else nextBaud_s = baudCnt_r + 16'd1;

    case (state_r)
      IDLE: begin
        if (!fifoEmpty_s) loadFrame_s = 1'b1;
        else nextState_s = IDLE;
      end
      START: begin
        if (bitEnd_s) begin
          nextState_s  = DATA;
          nextBitIdx_s = 3'd0;
        end else begin
          nextState_s = START;
        end
      end
      DATA: begin
        if (bitEnd_s) begin
          nextShift_s  = {1'b0, shift_r[7:1]};
          nextBitIdx_s = bitIdx_r + 3'd1;
          if (bitIdx_r == 3'd7) nextState_s = AFTER_DATA;
          else nextState_s = DATA;
        end else begin
          nextState_s = DATA;
        end
      end
`ifdef IOBUS_UART_PARITY_EN
      PARITY: begin
        if (bitEnd_s) nextState_s = STOP;
        else nextState_s = PARITY;
      end
`endif
      STOP: begin
        if (bitEnd_s) begin
          if (!fifoEmpty_s) loadFrame_s = 1'b1;
          else nextState_s = IDLE;
        end else begin
          nextState_s = STOP;
        end
      end
      default: nextState_s = IDLE;
    endcase

    // Frame start: the period is captured here so mid-frame BAUD_DIV writes wait for the next frame.
    if (loadFrame_s) begin
      nextState_s  = START;
      nextShift_s  = fifoDout_s;
      nextPeriod_s = baudDiv_r;
      nextBaud_s   = 16'd0;
    end else begin
      nextPeriod_s = bitPeriod_r;
    end
    popReq_s = loadFrame_s;

`ifdef IOBUS_UART_PARITY_EN
    if (loadFrame_s) nextParity_s = evenParity(fifoDout_s);
    else nextParity_s = parity_r;
`endif

    case (nextState_s)
      START:   nextTxd_s = 1'b0;
      DATA:    nextTxd_s = nextShift_s[0];
`ifdef IOBUS_UART_PARITY_EN
      PARITY:  nextTxd_s = nextParity_s;
`endif
      default: nextTxd_s = 1'b1;
    endcase
  end

  // Serialiser state registers.
  always_ff @(posedge CPU_CLK or negedge CPU_RST_N) begin
    if (!CPU_RST_N) begin
      state_r     <= IDLE;
      baudCnt_r   <= 16'd0;
      bitPeriod_r <= DIV_RESET;
      bitIdx_r    <= 3'd0;
      shift_r     <= 8'd0;
      txd_r       <= 1'b1;
`ifdef IOBUS_UART_PARITY_EN
      parity_r    <= 1'b0;
`endif
    end else begin
      state_r     <= nextState_s;
      baudCnt_r   <= nextBaud_s;
      bitPeriod_r <= nextPeriod_s;
      bitIdx_r    <= nextBitIdx_s;
      shift_r     <= nextShift_s;
      txd_r       <= nextTxd_s;
`ifdef IOBUS_UART_PARITY_EN
      parity_r    <= nextParity_s;
`endif
    end
  end

  assign UART_TXD = txd_r;

endmodule

// File: tb/tb_iobus_uart_tx.sv
// Self-checking bench for iobus_uart_tx: bus register checks plus a scoreboard-driven line monitor.
`timescale 1ns/1ps
module tb_iobus_uart_tx;

  localparam logic [31:0] BASE = 32'h1100_0100;
`ifdef IOBUS_UART_PARITY_EN
  localparam int          NBITS  = 11;
  localparam logic [31:0] PARBIT = 32'h0000_0010;
`else
  localparam int          NBITS  = 10;
  localparam logic [31:0] PARBIT = 32'h0000_0000;
`endif

  logic        CPU_CLK    = 1'b0;
  logic        CPU_RST_N  = 1'b1;
  logic [31:0] IOBUS_ADDR = 32'd0;
  logic [31:0] IOBUS_OUT  = 32'd0;
  logic        IOBUS_WR   = 1'b0;
  logic [31:0] RD_DATA;
  logic        RD_HIT;
  logic        UART_TXD;

  int checks = 0;
  int fails  = 0;

  typedef struct {
    logic [7:0] data;
    int         div;
    bit         b2b;
  } exp_t;

  exp_t sb[$];
  bit   monEn     = 1'b0;
  bit   monActive = 1'b0;

  iobus_uart_tx #(
    .BASE_ADDR  (BASE),
    .FIFO_DEPTH (16),
    .DIV_RESET  (16'd868)
  ) dut (
    .CPU_CLK    (CPU_CLK),
    .CPU_RST_N  (CPU_RST_N),
    .IOBUS_ADDR (IOBUS_ADDR),
    .IOBUS_OUT  (IOBUS_OUT),
    .IOBUS_WR   (IOBUS_WR),
    .RD_DATA    (RD_DATA),
    .RD_HIT     (RD_HIT),
    .UART_TXD   (UART_TXD)
  );

  always #5 CPU_CLK = ~CPU_CLK;

  function automatic exp_t mkExp(input logic [7:0] d, input int div, input bit b2b);
    exp_t e;
    e.data = d;
    e.div  = div;
    e.b2b  = b2b;
    return e;
  endfunction

  // Required line level for bit slot k of a frame carrying d.
  function automatic logic expLevel(input logic [7:0] d, input int k);
    if (k == 0) return 1'b0;
    else if (k <= 8) return d[k-1];
    else if ((NBITS == 11) && (k == 9)) return ^d;
    else return 1'b1;
  endfunction

  // Drives one store; sampled at the next posedge, returns at the following negedge.
  task automatic busWrite(input logic [31:0] a, input logic [31:0] d);
    IOBUS_ADDR = a;
    IOBUS_OUT  = d;
    IOBUS_WR   = 1'b1;
    @(negedge CPU_CLK);
    IOBUS_WR   = 1'b0;
  endtask

  task automatic busRead(input logic [31:0] a, output logic [31:0] d, output logic h);
    IOBUS_WR   = 1'b0;
    IOBUS_ADDR = a;
    #1;
    d = RD_DATA;
    h = RD_HIT;
  endtask

  // Line monitor: pops the scoreboard at each start bit and checks every cycle of the frame.
  initial begin
    exp_t   cur;
    int     monT      = 0;
    longint negCnt    = 0;
    longint lastEnd   = -100;
    bit     monBad    = 1'b0;
    bit     skip      = 1'b0;
    int     badT      = 0;
    logic   badGot    = 1'b0;
    cur = mkExp(8'h00, 16, 1'b0);
    forever begin
      @(negedge CPU_CLK);
      negCnt++;
      if (!monEn || !CPU_RST_N) begin
        monActive = 1'b0;
      end else if (monActive) begin
        if ((UART_TXD !== expLevel(cur.data, monT / cur.div)) && !monBad) begin
          monBad = 1'b1;
          badT   = monT;
          badGot = UART_TXD;
        end
        monT++;
        if (monT == NBITS * cur.div) begin
          monActive = 1'b0;
          lastEnd   = negCnt + 1;
          if (!skip) begin
            checks++;
            if (monBad) begin
              fails++;
              $display("FAIL frame data=%h div=%0d: line %b at cycle %0d of frame, required %b",
                       cur.data, cur.div, badGot, badT, expLevel(cur.data, badT / cur.div));
            end
          end
        end
      end else if (UART_TXD === 1'b0) begin
        monActive = 1'b1;
        monT      = 1;
        monBad    = 1'b0;
        skip      = 1'b0;
        checks++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL unexpected_frame: start bit seen, required no frame (scoreboard empty)");
          cur  = mkExp(8'h00, 16, 1'b0);
          skip = 1'b1;
        end else begin
          cur = sb.pop_front();
          if (cur.b2b && (negCnt != lastEnd)) begin
            fails++;
            $display("FAIL b2b_gap data=%h: %0d idle cycles before start, required 0",
                     cur.data, negCnt - lastEnd);
          end
        end
      end
    end
  end

  // Waits for the transmitter to go quiet, then requires the scoreboard to be empty.
  task automatic waitDrain(input int budget);
    logic [31:0] d;
    logic        h;
    int          n;
    for (n = 0; n < budget; n++) begin
      @(negedge CPU_CLK);
      busRead(BASE + 32'h4, d, h);
      if ((d[0] == 1'b0) && (d[2] == 1'b1) && !monActive) break;
    end
    checks++;
    if (n >= budget) begin
      fails++;
      $display("FAIL drain_timeout: still busy after %0d cycles, required idle", budget);
    end
    checks++;
    if (sb.size() != 0) begin
      fails++;
      $display("FAIL scoreboard_leftover: %0d frames outstanding, required 0", sb.size());
    end
  endtask

  task automatic test_reset();
    logic [31:0] d;
    logic        h;
    #3 CPU_RST_N = 1'b0;
    repeat (3) @(negedge CPU_CLK);
    checks++;
    if (UART_TXD !== 1'b1) begin
      fails++;
      $display("FAIL reset_txd: got %b, required 1", UART_TXD);
    end
    CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if ((d !== (32'h0000_0004 | PARBIT)) || (h !== 1'b1)) begin
      fails++;
      $display("FAIL reset_status: got %h hit %b, required %h hit 1", d, h, 32'h4 | PARBIT);
    end
    busRead(BASE + 32'h8, d, h);
    checks++;
    if ((d !== 32'd868) || (h !== 1'b1)) begin
      fails++;
      $display("FAIL reset_baud: got %0d hit %b, required 868 hit 1", d, h);
    end
    busRead(BASE, d, h);
    checks++;
    if ((d !== 32'd0) || (h !== 1'b1)) begin
      fails++;
      $display("FAIL txdata_read: got %h hit %b, required 0 hit 1", d, h);
    end
  endtask

  task automatic test_basic();
    logic [31:0] d;
    logic        h;
    busWrite(BASE + 32'h8, 32'd16);
    sb.push_back(mkExp(8'h55, 16, 1'b0));
    busWrite(BASE, 32'h55);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if ((UART_TXD !== 1'b1) || (d !== (32'h0000_0100 | PARBIT))) begin
      fails++;
      $display("FAIL basic_after_write: txd %b status %h, required txd 1 status %h", UART_TXD, d, 32'h100 | PARBIT);
    end
    @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if ((UART_TXD !== 1'b0) || (d !== (32'h0000_0005 | PARBIT))) begin
      fails++;
      $display("FAIL basic_start: txd %b status %h, required txd 0 status %h", UART_TXD, d, 32'h5 | PARBIT);
    end
    repeat (NBITS * 16 - 1) @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d[0] !== 1'b1) begin
      fails++;
      $display("FAIL basic_busy_last: busy %b in last frame cycle, required 1", d[0]);
    end
    @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if ((d[0] !== 1'b0) || (UART_TXD !== 1'b1)) begin
      fails++;
      $display("FAIL basic_busy_end: busy %b txd %b after frame, required busy 0 txd 1", d[0], UART_TXD);
    end
    waitDrain(50);
  endtask

  task automatic test_fifo_overrun();
    logic [31:0] d;
    logic        h;
    sb.push_back(mkExp(8'hC3, 16, 1'b0));
    busWrite(BASE, 32'hC3);
    repeat (4) @(negedge CPU_CLK);
    for (int i = 0; i < 17; i++) begin
      if (i < 16) sb.push_back(mkExp(i[7:0], 16, 1'b1));
      busWrite(BASE, 32'(i));
    end
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d !== (32'h0000_100B | PARBIT)) begin
      fails++;
      $display("FAIL fifo_full_overrun: status %h, required %h", d, 32'h100B | PARBIT);
    end
  endtask

  task automatic test_clear_overrun();
    logic [31:0] d;
    logic        h;
    busWrite(BASE + 32'h4, 32'hFFFF_FFF7);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d !== (32'h0000_100B | PARBIT)) begin
      fails++;
      $display("FAIL status_write_no_clear: status %h, required %h", d, 32'h100B | PARBIT);
    end
    busWrite(BASE + 32'h4, 32'h0000_0008);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d !== (32'h0000_1003 | PARBIT)) begin
      fails++;
      $display("FAIL overrun_clear: status %h, required %h", d, 32'h1003 | PARBIT);
    end
    waitDrain(17 * 16 * NBITS + 300);
  endtask

  task automatic test_baud();
    logic [31:0] d;
    logic        h;
    busWrite(BASE + 32'h8, 32'd5);
    busRead(BASE + 32'h8, d, h);
    checks++;
    if (d !== 32'd16) begin
      fails++;
      $display("FAIL baud_clamp: got %0d, required 16", d);
    end
    busWrite(BASE + 32'h8, 32'd17);
    busRead(BASE + 32'h8, d, h);
    checks++;
    if (d !== 32'd17) begin
      fails++;
      $display("FAIL baud_17: got %0d, required 17", d);
    end
    busWrite(BASE + 32'h8, 32'd16);
    sb.push_back(mkExp(8'h3C, 16, 1'b0));
    sb.push_back(mkExp(8'h96, 100, 1'b1));
    busWrite(BASE, 32'h3C);
    busWrite(BASE, 32'h96);
    repeat (40) @(negedge CPU_CLK);
    busWrite(BASE + 32'h8, 32'd100);
    busRead(BASE + 32'h8, d, h);
    checks++;
    if (d !== 32'd100) begin
      fails++;
      $display("FAIL baud_100: got %0d, required 100", d);
    end
    waitDrain(116 * NBITS + 300);
  endtask

  task automatic test_reset_mid();
    logic [31:0] d;
    logic        h;
    bit          sawLow;
    monEn = 1'b0;
    busWrite(BASE + 32'h8, 32'd16);
    busWrite(BASE, 32'hA3);
    repeat (57) @(negedge CPU_CLK);
    checks++;
    if (UART_TXD !== 1'b0) begin
      fails++;
      $display("FAIL pre_reset_bit2: txd %b, required 0", UART_TXD);
    end
    #2 CPU_RST_N = 1'b0;
    #1;
    checks++;
    if (UART_TXD !== 1'b1) begin
      fails++;
      $display("FAIL async_reset_txd: txd %b, required 1", UART_TXD);
    end
    repeat (2) @(negedge CPU_CLK);
    CPU_RST_N = 1'b1;
    @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d !== (32'h0000_0004 | PARBIT)) begin
      fails++;
      $display("FAIL reset_mid_status: status %h, required %h", d, 32'h4 | PARBIT);
    end
    busRead(BASE + 32'h8, d, h);
    checks++;
    if (d !== 32'd868) begin
      fails++;
      $display("FAIL reset_mid_baud: got %0d, required 868", d);
    end
    sawLow = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge CPU_CLK);
      if (UART_TXD !== 1'b1) sawLow = 1'b1;
    end
    checks++;
    if (sawLow) begin
      fails++;
      $display("FAIL no_resume: line left idle after reset, required constant 1");
    end
    busWrite(BASE + 32'h8, 32'd16);
    monEn = 1'b1;
  endtask

  task automatic test_window();
    logic [31:0] d;
    logic        h;
    busRead(BASE + 32'hC, d, h);
    checks++;
    if ((d !== 32'd0) || (h !== 1'b0)) begin
      fails++;
      $display("FAIL window_0xC: data %h hit %b, required 0 hit 0", d, h);
    end
    busRead(BASE - 32'h4, d, h);
    checks++;
    if ((d !== 32'd0) || (h !== 1'b0)) begin
      fails++;
      $display("FAIL window_below: data %h hit %b, required 0 hit 0", d, h);
    end
    busRead(BASE + 32'h6, d, h);
    checks++;
    if ((d !== (32'h0000_0004 | PARBIT)) || (h !== 1'b1)) begin
      fails++;
      $display("FAIL unaligned_status: data %h hit %b, required %h hit 1", d, h, 32'h4 | PARBIT);
    end
    busWrite(BASE + 32'hC, 32'h55);
    busWrite(BASE + 32'h10, 32'h55);
    busWrite(BASE - 32'h4, 32'h55);
    repeat (5) @(negedge CPU_CLK);
    busRead(BASE + 32'h4, d, h);
    checks++;
    if (d !== (32'h0000_0004 | PARBIT)) begin
      fails++;
      $display("FAIL miss_writes_ignored: status %h, required %h", d, 32'h4 | PARBIT);
    end
    busRead(BASE + 32'h8, d, h);
    checks++;
    if (d !== 32'd16) begin
      fails++;
      $display("FAIL miss_baud_unchanged: got %0d, required 16", d);
    end
  endtask

  task automatic test_parity();
    sb.push_back(mkExp(8'h07, 16, 1'b0));
    busWrite(BASE, 32'h07);
    waitDrain(16 * NBITS + 100);
  endtask

  initial begin
    test_reset();
    monEn = 1'b1;
    test_basic();
    test_fifo_overrun();
    test_clear_overrun();
    test_baud();
    test_reset_mid();
    test_window();
    test_parity();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation exceeded 2 ms, required completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/iobus_uart_tx.md
Name: iobus_uart_tx

Overview:
- Memory-mapped UART transmitter on the responder side of the CPU IO bus.
- Decodes the CPU store address, write data and write strobe. Bytes written to TXDATA are queued in a FIFO and serialised 8N1, LSB first, on UART_TXD.
- Supplies read data for the status and baud registers, for the top-level IOBUS_IN read mux.

Parameters:
- BASE_ADDR, 32'h1100_0100, base byte address of the 3-register window.
- FIFO_DEPTH, 16, TX FIFO entries; must be a power of 2, minimum 2.
- DIV_RESET, 868, reset value of BAUD_DIV (clocks per bit; 100 MHz / 115200).

Ports:
- CPU_CLK  input  1  system clock, all logic on the rising edge.
- CPU_RST_N  input  1  asynchronous, active-low reset.
- IOBUS_ADDR  input  32  CPU IO byte address, valid in the same cycle as IOBUS_WR.
- IOBUS_OUT  input  32  CPU store data.
- IOBUS_WR  input  1  one-cycle write strobe per store.
- RD_DATA  output  32  combinational read data for IOBUS_ADDR; 0 when not hit.
- RD_HIT  output  1  IOBUS_ADDR falls inside the register window.
- UART_TXD  output  1  serial line; idle level is high.

Behaviour:
- Register map (offset from BASE_ADDR; word-aligned, ADDR[1:0] ignored):
  - 0x0 TXDATA, write-only. Write pushes IOBUS_OUT[7:0]. Reads return 0.
  - 0x4 STATUS, read: bit0 busy (FSM not IDLE), bit1 full, bit2 empty, bit3 overrun (sticky), bits[12:8] count, others 0. Write with IOBUS_OUT[3]=1 clears overrun; all other bits ignored.
  - 0x8 BAUD_DIV, RW, 16 bits; reads zero-extended. Writes of values below 16 are stored as 16.
  - 0xC, plus any address outside the window: RD_HIT=0, RD_DATA=0, writes ignored.
- Reads have no side effects; RD_DATA is purely combinational.
- Reset values: UART_TXD=1, FIFO empty, count=0, overrun=0, BAUD_DIV=DIV_RESET, FSM=IDLE, bit counter and baud counter 0.
- Reset is asynchronous, so UART_TXD returns to 1 immediately even mid-frame. The partial frame is abandoned and the FIFO is flushed.
- FIFO rules:
  - Push while full (and no pop that cycle): data dropped, overrun set.
  - Push and pop in the same cycle: both happen, count unchanged, also when full.
  - Pointers wrap modulo FIFO_DEPTH.
  - count ranges 0..FIFO_DEPTH; full when count==FIFO_DEPTH.
- FSM states IDLE -> START -> DATA -> STOP -> (IDLE or START):
  - IDLE: UART_TXD=1. If FIFO non-empty: pop into shift register, latch BAUD_DIV into the bit-period register, go to START.
  - START: TXD=0 for one bit period.
  - DATA: TXD=shift[0]; shift right every bit period; 8 bits, bit index 0..7.
  - STOP: TXD=1 for one bit period. At the end, if FIFO non-empty, pop and go directly to START (back-to-back frames, no idle gap); else go to IDLE.
- Bit period:
  - Baud counter counts 0..div-1; the bit ends when count==div-1.
  - A BAUD_DIV write mid-frame takes effect at the next frame start only.
- Latency: TXDATA write sampled at edge E0. FIFO non-empty after E0, pop at E1, UART_TXD low in the cycle after E1. The whole frame is 10*div cycles.
- UART_TXD is driven from a flop (glitch-free).

Optional Feature:
- Macro: IOBUS_UART_PARITY_EN.
- Defined: adds a PARITY state between DATA and STOP. Transmits the even parity bit (XOR of the 8 data bits) for one bit period, giving an 11-bit 8E1 frame. STATUS bit4 reads 1.
- Undefined: no PARITY state, 8N1 10-bit frame, STATUS bit4 reads 0.

Decomposition:
- Package iobus_uart_pkg holds:
  - register offset constants: TXDATA_OFS, STATUS_OFS, BAUD_OFS;
  - STATUS bit-position constants;
  - MIN_DIV=16;
  - the tx_state_t enum (IDLE, START, DATA, PARITY, STOP).
- One sub-module, uart_tx_fifo: synchronous FIFO with push, pop, din, dout, full, empty and count, parameterised on depth and width.

Test Plan:
- Reset, then BAUD_DIV=16. Write 0x55 to TXDATA -> TXD low 2 cycles after the write. Then bits 1,0,1,0,1,0,1,0, each 16 cycles, then stop high. Total frame 160 cycles; STATUS busy=1 during the frame, 0 after.
- Write 17 bytes 0x00..0x10 at 1/cycle while the first frame is sending -> first byte pops. Count reaches 16, full=1, the last write sets overrun=1 and is not transmitted. Frames are back-to-back with no idle cycles between stop and start.
- Write STATUS with 0x8 -> overrun reads 0; other STATUS fields unchanged.
- Write 5 to BAUD_DIV -> reads back 16. Write 100 mid-frame -> current frame keeps its period, next frame uses 100 cycles/bit.
- Assert CPU_RST_N low during DATA of byte 0xA3 -> TXD=1 asynchronously, count=0, BAUD_DIV=868, no resumed transmission after reset release.
- Read at BASE_ADDR+0xC and BASE_ADDR-4 -> RD_HIT=0, RD_DATA=0. With IOBUS_UART_PARITY_EN, byte 0x07 -> parity bit 1, frame 11 bit periods.
